ripple_count_sampler: RTL and testbench



---
 rtl/ripple_count_sampler_pkg.sv | 22 ++
 rtl/ripple_count_sampler_if.sv | 16 +
 rtl/ripple_count_sampler_bus_sync2.sv | 23 ++
 rtl/ripple_count_sampler.sv | 122 ++++++++++++
 tb/tb_ripple_count_sampler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ripple_count_sampler_pkg.sv
// Shared types and sizing helpers for the ripple counter sampler.
// Keeps default parameters and counter width rules in one place.
package ripple_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_ACC_WIDTH    = 16;
    localparam int DEF_STABLE_READS = 2;
    localparam int DEF_WINDOW       = 256;
    localparam int DEF_TIMEOUT      = 16;

    // Bits needed for a counter that runs 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ripple_count_sampler_if.sv
// Result bus of the sampler: per-window delta plus running total,
// transferred on out_valid && out_ready.
interface ripple_count_sampler_if
    import ripple_sampler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
    logic [WIDTH-1:0]     delta_out;
    logic [ACC_WIDTH-1:0] total_out;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output delta_out, output total_out, output out_valid, input out_ready);
    modport slave  (input delta_out, input total_out, input out_valid, output out_ready);
endinterface

// File: rtl/ripple_count_sampler_bus_sync2.sv
// Two-flop bus synchronizer; only dout (second stage) may be used downstream.
// Latency: 2 cycles. No backpressure.
// Bits may resolve independently, so the consumer must tolerate torn values.
module bus_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= '0;
            dout <= '0;
        end else begin
            s1   <= din;
            dout <= s1;
        end
    end
endmodule

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple counter, rejects mid-ripple reads, emits per-window delta and total.
// Latency: tick to out_valid is STABLE_READS+1 cycles with a stable counter.
// Backpressure: result held in EMIT until out_ready; window ticks arriving while busy are dropped and flag overrun.
module ripple_count_sampler
    import ripple_sampler_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int STABLE_READS = DEF_STABLE_READS,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      cnt_in,
    input  logic                  start,
    ripple_count_sampler_if.master out_bus,
    output logic                  overrun,
    output logic                  unstable_err
);
    localparam int MW = cnt_width(STABLE_READS);
    localparam int TW = cnt_width(TIMEOUT);
    localparam int WW = cnt_width(WINDOW);

    localparam logic [MW-1:0] MATCH_LAST = MW'(STABLE_READS - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);

    logic [WIDTH-1:0]     s2;
    logic [WIDTH-1:0]     cand;
    logic [WIDTH-1:0]     prev;
    logic [WIDTH-1:0]     diff;
    logic [MW-1:0]        match_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [WW-1:0]        win_cnt;
    logic                 tick;
    logic                 accept;
    state_t               state;
    logic [WIDTH-1:0]     delta_q;
    logic [ACC_WIDTH-1:0] total_q;
    logic                 valid_q;

    bus_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cnt_in),
        .dout (s2)
    );

    always_ff @(posedge clk) begin
        if (rst || !start) begin
            win_cnt <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    assign tick   = start && (win_cnt == WIN_LAST);
    assign accept = (s2 == cand) && (match_cnt == MATCH_LAST);
    assign diff   = cand - prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cand         <= '0;
            prev         <= '0;
            match_cnt    <= '0;
            tmo_cnt      <= '0;
            delta_q      <= '0;
            total_q      <= '0;
            valid_q      <= 1'b0;
            overrun      <= 1'b0;
            unstable_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        cand      <= s2;
                        match_cnt <= '0;
                        tmo_cnt   <= '0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tick) overrun <= 1'b1;
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (accept) begin
                        delta_q <= diff;
                        total_q <= total_q + ACC_WIDTH'(diff);
                        prev    <= cand;
                        valid_q <= 1'b1;
                        state   <= EMIT;
                    end else if (s2 == cand) begin
                        match_cnt <= match_cnt + 1'b1;
                    end else begin
                        cand      <= s2;
                        match_cnt <= '0;
                    end
                    // An accept on the final allowed cycle still wins over the timeout.
                    if (!accept && (tmo_cnt == TMO_LAST)) begin
                        unstable_err <= 1'b1;
                        state        <= IDLE;
                    end
                end
                EMIT: begin
                    if (tick) overrun <= 1'b1;
                    if (valid_q && out_bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_bus.delta_out = delta_q;
    assign out_bus.total_out = total_q;
    assign out_bus.out_valid = valid_q;
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Drives per-phase stimulus tables into the sampler and compares every cycle
// against a transaction-level model built from the same tables.
module tb_ripple_count_sampler;
    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 16;
    localparam int SR        = 2;
    localparam int WINDOW    = 8;
    localparam int TIMEOUT   = 16;
    localparam int NMAX      = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] cnt_in;
    logic             overrun;
    logic             unstable_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ripple_count_sampler_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    ripple_count_sampler #(
        .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .STABLE_READS(SR),
        .WINDOW(WINDOW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt_in       (cnt_in),
        .start        (start),
        .out_bus      (bus),
        .overrun      (overrun),
        .unstable_err (unstable_err)
    );

    logic [WIDTH-1:0]     st_cin   [NMAX];
    bit                   st_start [NMAX];
    bit                   st_rdy   [NMAX];
    bit                   m_valid  [NMAX];
    bit                   m_ov     [NMAX];
    bit                   m_ue     [NMAX];
    logic [WIDTH-1:0]     m_delta  [NMAX];
    logic [ACC_WIDTH-1:0] m_total  [NMAX];
    logic                 a_valid  [NMAX];
    logic                 a_ov     [NMAX];
    logic                 a_ue     [NMAX];
    logic [WIDTH-1:0]     a_delta  [NMAX];
    logic [ACC_WIDTH-1:0] a_total  [NMAX];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: synchronized value is the input two cycles earlier; a window tick
    // while idle starts a capture that accepts at the first run of SR+1 equal
    // synchronized values starting at the tick, or gives up after TIMEOUT cycles.
    task automatic build_model(input int n);
        logic [WIDTH-1:0]     s2 [NMAX];
        bit                   tk [NMAX];
        int                   run, busy_until, set_at, ue_at, clr_at, acc;
        bit                   same, found, vld, ov, ue, ov_next;
        logic [WIDTH-1:0]     prev, dl, pend_dl;
        logic [ACC_WIDTH-1:0] tot, pend_tot;
        run = 0;
        for (int c = 0; c < n; c++) begin
            s2[c] = (c < 2) ? '0 : st_cin[c-2];
            tk[c] = st_start[c] && ((run % WINDOW) == WINDOW - 1);
            run   = st_start[c] ? run + 1 : 0;
        end
        prev = '0; dl = '0; tot = '0; pend_dl = '0; pend_tot = '0;
        vld = 0; ov = 0; ue = 0; ov_next = 0;
        busy_until = -1; set_at = -1; ue_at = -1; clr_at = -1;
        for (int c = 0; c < n; c++) begin
            if (ov_next) ov = 1;
            ov_next = 0;
            if (c == set_at) begin vld = 1; dl = pend_dl; tot = pend_tot; end
            if (c == clr_at) vld = 0;
            if (c == ue_at)  ue = 1;
            m_valid[c] = vld; m_delta[c] = dl; m_total[c] = tot;
            m_ov[c] = ov; m_ue[c] = ue;
            if (tk[c]) begin
                if (c <= busy_until) begin
                    ov_next = 1;
                end else begin
                    acc = -1;
                    for (int j = SR; j <= TIMEOUT && c + j < n && acc < 0; j++) begin
                        same = 1;
                        for (int k = 1; k <= SR; k++)
                            if (s2[c+j-k] != s2[c+j]) same = 0;
                        if (same) acc = c + j;
                    end
                    if (acc >= 0) begin
                        pend_dl  = s2[acc] - prev;
                        pend_tot = tot + ACC_WIDTH'(pend_dl);
                        prev     = s2[acc];
                        set_at   = acc + 1;
                        busy_until = n;
                        found = 0;
                        for (int x = acc + 1; x < n; x++)
                            if (!found && st_rdy[x]) begin busy_until = x; found = 1; end
                        clr_at = busy_until + 1;
                    end else if (c + TIMEOUT < n) begin
                        ue_at      = c + TIMEOUT + 1;
                        busy_until = c + TIMEOUT;
                    end else begin
                        busy_until = n;
                    end
                end
            end
        end
    endtask

    task automatic run_phase(input string name, input int n);
        build_model(n);
        rst = 1'b1; start = 1'b0; bus.out_ready = 1'b0; cnt_in = 4'hA;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            rst = 1'b0;
            cnt_in = st_cin[c]; start = st_start[c]; bus.out_ready = st_rdy[c];
            @(negedge clk);
            a_valid[c] = bus.out_valid; a_delta[c] = bus.delta_out; a_total[c] = bus.total_out;
            a_ov[c] = overrun; a_ue[c] = unstable_err;
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < n; c++) begin
            check_val($sformatf("%s.valid@%0d", name, c), 32'(a_valid[c]), 32'(m_valid[c]));
            check_val($sformatf("%s.delta@%0d", name, c), 32'(a_delta[c]), 32'(m_delta[c]));
            check_val($sformatf("%s.total@%0d", name, c), 32'(a_total[c]), 32'(m_total[c]));
            check_val($sformatf("%s.ovr@%0d", name, c),   32'(a_ov[c]),    32'(m_ov[c]));
            check_val($sformatf("%s.uerr@%0d", name, c),  32'(a_ue[c]),    32'(m_ue[c]));
        end
    endtask

    task automatic fill(input int n, input logic [WIDTH-1:0] v, input bit rdy);
        for (int c = 0; c < n; c++) begin
            st_cin[c] = v; st_start[c] = 1'b1; st_rdy[c] = rdy;
        end
    endtask

    task automatic gen_random(input int n);
        logic [WIDTH-1:0] v;
        bit               s;
        int               r;
        v = WIDTH'($urandom);
        s = 1'b1;
        for (int c = 0; c < n; c++) begin
            r = $urandom_range(0, 99);
            if (r < 25) v = v + WIDTH'($urandom_range(1, 3));
            st_cin[c] = (r >= 90) ? WIDTH'($urandom) : v;
            if ($urandom_range(0, 99) < 4) s = !s;
            st_start[c] = s;
            st_rdy[c]   = ($urandom_range(0, 99) < 65);
        end
    endtask

    int nv;

    initial begin
        // reset value, then basic measurement: 5 then 9 -> deltas 5 and 4
        fill(30, 4'd5, 1'b1);
        for (int c = 11; c < 30; c++) st_cin[c] = 4'd9;
        run_phase("basic", 30);
        check_val("rst.valid", 32'(a_valid[0]), 32'd0);
        check_val("rst.total", 32'(a_total[0]), 32'd0);
        check_val("rst.delta", 32'(a_delta[0]), 32'd0);
        check_val("basic.lat_pre", 32'(a_valid[9]), 32'd0);
        check_val("basic.lat", 32'(a_valid[10]), 32'd1);
        check_val("basic.d1", 32'(a_delta[10]), 32'd5);
        check_val("basic.t1", 32'(a_total[10]), 32'd5);
        check_val("basic.hs", 32'(a_valid[11]), 32'd0);
        check_val("basic.d2", 32'(a_delta[18]), 32'd4);
        check_val("basic.t2", 32'(a_total[18]), 32'd9);

        fill(22, 4'd14, 1'b1);
        for (int c = 11; c < 22; c++) st_cin[c] = 4'd3;
        run_phase("wrap", 22);
        check_val("wrap.d", 32'(a_delta[18]), 32'd5);
        check_val("wrap.t", 32'(a_total[18]), 32'd19);

        fill(16, 4'd8, 1'b1);
        for (int c = 0; c < 6; c++) st_cin[c] = 4'd7;
        st_cin[6] = 4'd6; st_cin[7] = 4'd4;
        run_phase("ripple", 16);
        check_val("ripple.early", 32'(a_valid[12]), 32'd0);
        check_val("ripple.valid", 32'(a_valid[13]), 32'd1);
        check_val("ripple.d", 32'(a_delta[13]), 32'd8);

        fill(40, 4'd3, 1'b1);
        for (int c = 0; c < 26; c++) st_cin[c] = c[0] ? 4'hF : 4'h0;
        run_phase("tmo", 40);
        nv = 0;
        for (int c = 0; c < 34; c++) nv += int'(a_valid[c]);
        check_val("tmo.no_emit", 32'(nv), 32'd0);
        check_val("tmo.uerr_pre", 32'(a_ue[23]), 32'd0);
        check_val("tmo.uerr", 32'(a_ue[24]), 32'd1);
        check_val("tmo.ovr", 32'(a_ov[16]), 32'd1);
        check_val("tmo.prev_kept", 32'(a_delta[34]), 32'd3);

        fill(30, 4'd6, 1'b1);
        for (int c = 9; c < 30; c++) st_start[c] = 1'b0;
        run_phase("stop", 30);
        nv = 0;
        for (int c = 0; c < 30; c++) nv += int'(a_valid[c]);
        check_val("stop.emit", 32'(a_valid[10]), 32'd1);
        check_val("stop.d", 32'(a_delta[10]), 32'd6);
        check_val("stop.once", 32'(nv), 32'd1);

        // backpressure, then reset while the next capture is settling
        fill(25, 4'd5, 1'b0);
        for (int c = 20; c < 25; c++) st_rdy[c] = 1'b1;
        run_phase("bp", 25);
        check_val("bp.held_v", 32'(a_valid[19]), 32'd1);
        check_val("bp.held_d", 32'(a_delta[19]), 32'd5);
        check_val("bp.ovr_pre", 32'(a_ov[15]), 32'd0);
        check_val("bp.ovr", 32'(a_ov[16]), 32'd1);
        check_val("bp.done", 32'(a_valid[21]), 32'd0);
        check_val("bp.keep_d", 32'(a_delta[21]), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_val("midrst.valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst.total", 32'(bus.total_out), 32'd0);
        check_val("midrst.delta", 32'(bus.delta_out), 32'd0);
        check_val("midrst.ovr", 32'(overrun), 32'd0);
        repeat (4) @(negedge clk);
        check_val("midrst.idle", 32'(bus.out_valid), 32'd0);

        for (int p = 0; p < 4; p++) begin
            gen_random(160);
            run_phase($sformatf("rand%0d", p), 160);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
